// File: rtl/hdu_mc.sv
// Multi-cycle hazard detection unit: load-use stall FSM, redirect flush, SRAM freeze.
// Optional perf counters enabled with macro HDU_PERF_CNT_EN.
module hdu_mc #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_USE_CYC = 1,
  parameter int unsigned FLUSH_STAGES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sram_stall,
  input  logic              i_EXMEM_pcsel,
  input  logic              i_EXMEM_is_br,
  input  logic              i_EXMEM_is_uncbr,
  input  logic              i_IDEX_rdwren,
  input  logic              i_IDEX_mem_rden,
  input  logic [REG_AW-1:0] i_IDEX_rd,
  input  logic [REG_AW-1:0] i_IFID_rs1,
  input  logic [REG_AW-1:0] i_IFID_rs2,
  input  logic              i_IFID_rs1_used,
  input  logic              i_IFID_rs2_used,
  output logic              o_pc_wren,
  output logic              o_IFID_wren,
  output logic              o_IDEX_wren,
  output logic              o_EXMEM_wren,
  output logic              o_MEMWB_wren,
  output logic              o_IFID_clear,
  output logic              o_IDEX_clear,
  output logic              o_EXMEM_clear,
  output logic [1:0]        o_state
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_cnt_lu,
  output logic [CNT_W-1:0]  o_cnt_flush,
  output logic [CNT_W-1:0]  o_cnt_frz
`endif
);

  if (LOAD_USE_CYC < 1 || LOAD_USE_CYC > 15) begin : g_bad_luc
    $error("hdu_mc: LOAD_USE_CYC must be in 1..15");
  end
  if (FLUSH_STAGES < 1 || FLUSH_STAGES > 3) begin : g_bad_flush
    $error("hdu_mc: FLUSH_STAGES must be in 1..3");
  end
  if (CNT_W < 1) begin : g_bad_cntw
    $error("hdu_mc: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FROZEN   = 2'b10
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       redirect, lu_hit, bubble;

  assign redirect = i_EXMEM_pcsel & (i_EXMEM_is_br | i_EXMEM_is_uncbr);
  assign lu_hit   = i_IDEX_mem_rden & i_IDEX_rdwren & (i_IDEX_rd != '0) &
                    ((i_IFID_rs1_used & (i_IDEX_rd == i_IFID_rs1)) |
                     (i_IFID_rs2_used & (i_IDEX_rd == i_IFID_rs2)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    bubble        = 1'b0;
    o_pc_wren     = 1'b0;
    o_IFID_wren   = 1'b0;
    o_IDEX_wren   = 1'b0;
    o_EXMEM_wren  = 1'b0;
    o_MEMWB_wren  = 1'b0;
    o_IFID_clear  = 1'b0;
    o_IDEX_clear  = 1'b0;
    o_EXMEM_clear = 1'b0;
    o_state       = state;
    if (!i_rst_n) begin
      o_state = RUN;
    end else if (i_sram_stall) begin
      o_state = FROZEN;
    end else if (redirect) begin
      o_pc_wren     = 1'b1;
      o_IFID_wren   = 1'b1;
      o_IDEX_wren   = 1'b1;
      o_EXMEM_wren  = 1'b1;
      o_MEMWB_wren  = 1'b1;
      o_IFID_clear  = 1'b1;
      o_IDEX_clear  = (FLUSH_STAGES >= 2);
      o_EXMEM_clear = (FLUSH_STAGES >= 3);
      state_nx      = RUN;
      cnt_nx        = '0;
    end else if (state == LU_STALL || lu_hit) begin
      // In LU_STALL the stall is held off the counter alone; IDEX already carries the bubble.
      bubble       = 1'b1;
      o_IDEX_wren  = 1'b1;
      o_EXMEM_wren = 1'b1;
      o_MEMWB_wren = 1'b1;
      o_IDEX_clear = 1'b1;
      if (state == LU_STALL) begin
        if (cnt == 4'd1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end else if (LOAD_USE_CYC > 1) begin
        state_nx = LU_STALL;
        cnt_nx   = 4'(LOAD_USE_CYC - 1);
      end
    end else begin
      o_pc_wren    = 1'b1;
      o_IFID_wren  = 1'b1;
      o_IDEX_wren  = 1'b1;
      o_EXMEM_wren = 1'b1;
      o_MEMWB_wren = 1'b1;
    end
  end

`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_lu    <= '0;
      o_cnt_flush <= '0;
      o_cnt_frz   <= '0;
    end else begin
      if (bubble && o_cnt_lu != '1)
        o_cnt_lu <= o_cnt_lu + 1'b1;
      if (!i_sram_stall && redirect && o_cnt_flush != '1)
        o_cnt_flush <= o_cnt_flush + 1'b1;
      if (i_sram_stall && o_cnt_frz != '1)
        o_cnt_frz <= o_cnt_frz + 1'b1;
    end
  end
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_hdu_mc.sv
// Directed bench for hdu_mc: two parameterisations share stimulus; a third checks perf counters.
module tb_hdu_mc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sram_stall, pcsel, is_br, is_uncbr;
  logic       idex_rdwren, idex_mem_rden;
  logic [4:0] idex_rd, rs1, rs2;
  logic       rs1_used, rs2_used;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] ALL = 8'b11111_000;
  localparam logic [7:0] LU  = 8'b00111_010;
  localparam logic [7:0] FRZ = 8'b00000_000;
  localparam logic [7:0] RD3 = 8'b11111_111;
  localparam logic [7:0] RD2 = 8'b11111_110;

  always #5 clk = ~clk;

  logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_c, a_idex_c, a_exmem_c;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_c, b_idex_c, b_exmem_c;
  logic [1:0] a_state, b_state;
  logic [9:0] obs_a, obs_b;

  assign obs_a = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_c, a_idex_c, a_exmem_c, a_state};
  assign obs_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_c, b_idex_c, b_exmem_c, b_state};

  hdu_mc #(.REG_AW(5), .LOAD_USE_CYC(1), .FLUSH_STAGES(3)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sram_stall(sram_stall),
    .i_EXMEM_pcsel(pcsel), .i_EXMEM_is_br(is_br), .i_EXMEM_is_uncbr(is_uncbr),
    .i_IDEX_rdwren(idex_rdwren), .i_IDEX_mem_rden(idex_mem_rden), .i_IDEX_rd(idex_rd),
    .i_IFID_rs1(rs1), .i_IFID_rs2(rs2), .i_IFID_rs1_used(rs1_used), .i_IFID_rs2_used(rs2_used),
    .o_pc_wren(a_pc), .o_IFID_wren(a_ifid), .o_IDEX_wren(a_idex), .o_EXMEM_wren(a_exmem),
    .o_MEMWB_wren(a_memwb), .o_IFID_clear(a_ifid_c), .o_IDEX_clear(a_idex_c),
    .o_EXMEM_clear(a_exmem_c), .o_state(a_state)
`ifdef HDU_PERF_CNT_EN
    , .o_cnt_lu(), .o_cnt_flush(), .o_cnt_frz()
`endif
  );

  hdu_mc #(.REG_AW(5), .LOAD_USE_CYC(3), .FLUSH_STAGES(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sram_stall(sram_stall),
    .i_EXMEM_pcsel(pcsel), .i_EXMEM_is_br(is_br), .i_EXMEM_is_uncbr(is_uncbr),
    .i_IDEX_rdwren(idex_rdwren), .i_IDEX_mem_rden(idex_mem_rden), .i_IDEX_rd(idex_rd),
    .i_IFID_rs1(rs1), .i_IFID_rs2(rs2), .i_IFID_rs1_used(rs1_used), .i_IFID_rs2_used(rs2_used),
    .o_pc_wren(b_pc), .o_IFID_wren(b_ifid), .o_IDEX_wren(b_idex), .o_EXMEM_wren(b_exmem),
    .o_MEMWB_wren(b_memwb), .o_IFID_clear(b_ifid_c), .o_IDEX_clear(b_idex_c),
    .o_EXMEM_clear(b_exmem_c), .o_state(b_state)
`ifdef HDU_PERF_CNT_EN
    , .o_cnt_lu(), .o_cnt_flush(), .o_cnt_frz()
`endif
  );

`ifdef HDU_PERF_CNT_EN
  logic c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_ifid_c, c_idex_c, c_exmem_c;
  logic [1:0]  c_state;
  logic [9:0]  obs_c;
  logic [31:0] c_cnt_lu, c_cnt_flush, c_cnt_frz;

  assign obs_c = {c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_ifid_c, c_idex_c, c_exmem_c, c_state};

  hdu_mc #(.REG_AW(5), .LOAD_USE_CYC(2), .FLUSH_STAGES(3), .CNT_W(32)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_sram_stall(sram_stall),
    .i_EXMEM_pcsel(pcsel), .i_EXMEM_is_br(is_br), .i_EXMEM_is_uncbr(is_uncbr),
    .i_IDEX_rdwren(idex_rdwren), .i_IDEX_mem_rden(idex_mem_rden), .i_IDEX_rd(idex_rd),
    .i_IFID_rs1(rs1), .i_IFID_rs2(rs2), .i_IFID_rs1_used(rs1_used), .i_IFID_rs2_used(rs2_used),
    .o_pc_wren(c_pc), .o_IFID_wren(c_ifid), .o_IDEX_wren(c_idex), .o_EXMEM_wren(c_exmem),
    .o_MEMWB_wren(c_memwb), .o_IFID_clear(c_ifid_c), .o_IDEX_clear(c_idex_c),
    .o_EXMEM_clear(c_exmem_c), .o_state(c_state),
    .o_cnt_lu(c_cnt_lu), .o_cnt_flush(c_cnt_flush), .o_cnt_frz(c_cnt_frz)
  );
`endif

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    sram_stall = 0; pcsel = 0; is_br = 0; is_uncbr = 0;
    idex_rdwren = 0; idex_mem_rden = 0; idex_rd = '0;
    rs1 = '0; rs2 = '0; rs1_used = 0; rs2_used = 0;
  endtask

  // lw x5 in IDEX, IFID reads x5 (rs1) and x7 (rs2)
  task automatic set_lu();
    set_idle();
    idex_rdwren = 1; idex_mem_rden = 1; idex_rd = 5'd5;
    rs1 = 5'd5; rs1_used = 1; rs2 = 5'd7; rs2_used = 1;
  endtask

  // IDEX now holds the inserted bubble; IFID keeps the dependent instruction
  task automatic set_bubble();
    idex_rdwren = 0; idex_mem_rden = 0; idex_rd = '0;
  endtask

  task automatic test_reset();
    set_lu();
    rst_n = 0;
    #1;
    total++;
    if (obs_a !== 10'b0) begin bad++; $display("FAIL reset_a: got=%b exp=%b", obs_a, 10'b0); end
    total++;
    if (obs_b !== 10'b0) begin bad++; $display("FAIL reset_b: got=%b exp=%b", obs_b, 10'b0); end
    cyc();
    set_idle();
    rst_n = 1;
    #1;
    total++;
    if (obs_a !== {ALL, 2'b00}) begin bad++; $display("FAIL normal_a: got=%b exp=%b", obs_a, {ALL, 2'b00}); end
    total++;
    if (obs_b !== {ALL, 2'b00}) begin bad++; $display("FAIL normal_b: got=%b exp=%b", obs_b, {ALL, 2'b00}); end
    cyc();
  endtask

  task automatic test_load_use();
    logic [9:0] ea [4];
    logic [9:0] eb [4];
    ea = '{{LU, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00}};
    eb = '{{LU, 2'b00}, {LU, 2'b01}, {LU, 2'b01}, {ALL, 2'b00}};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_lu(); else set_bubble();
      #1;
      total++;
      if (obs_a !== ea[i]) begin bad++; $display("FAIL lu_a[%0d]: got=%b exp=%b", i, obs_a, ea[i]); end
      total++;
      if (obs_b !== eb[i]) begin bad++; $display("FAIL lu_b[%0d]: got=%b exp=%b", i, obs_b, eb[i]); end
      cyc();
    end
    set_idle();
  endtask

  task automatic test_freeze();
    logic [9:0] ea [8];
    logic [9:0] eb [8];
    ea = '{{LU, 2'b00}, {FRZ, 2'b10}, {FRZ, 2'b10}, {FRZ, 2'b10}, {FRZ, 2'b10},
           {ALL, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00}};
    eb = '{{LU, 2'b00}, {FRZ, 2'b10}, {FRZ, 2'b10}, {FRZ, 2'b10}, {FRZ, 2'b10},
           {LU, 2'b01}, {LU, 2'b01}, {ALL, 2'b00}};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) set_lu(); else set_bubble();
      sram_stall = (i >= 1 && i <= 4);
      #1;
      total++;
      if (obs_a !== ea[i]) begin bad++; $display("FAIL frz_a[%0d]: got=%b exp=%b", i, obs_a, ea[i]); end
      total++;
      if (obs_b !== eb[i]) begin bad++; $display("FAIL frz_b[%0d]: got=%b exp=%b", i, obs_b, eb[i]); end
      cyc();
    end
    set_idle();
  endtask

  task automatic test_no_stall();
    logic [9:0] ea [7];
    logic [9:0] eb [7];
    ea = '{{ALL, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00}, {LU, 2'b00},
           {ALL, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00}};
    eb = '{{ALL, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00}, {LU, 2'b00},
           {LU, 2'b01}, {LU, 2'b01}, {ALL, 2'b00}};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin set_lu(); idex_rd = '0; rs1 = '0; end
        1: begin set_lu(); rs1 = 5'd3; rs2 = 5'd5; rs2_used = 0; end
        2: begin set_lu(); idex_rdwren = 0; end
        3: begin set_lu(); rs1 = 5'd3; rs2 = 5'd5; end
        default: set_bubble();
      endcase
      #1;
      total++;
      if (obs_a !== ea[i]) begin bad++; $display("FAIL nostall_a[%0d]: got=%b exp=%b", i, obs_a, ea[i]); end
      total++;
      if (obs_b !== eb[i]) begin bad++; $display("FAIL nostall_b[%0d]: got=%b exp=%b", i, obs_b, eb[i]); end
      cyc();
    end
    set_idle();
  endtask

  task automatic test_redirect();
    logic [9:0] ea [7];
    logic [9:0] eb [7];
    ea = '{{LU, 2'b00}, {RD3, 2'b00}, {ALL, 2'b00}, {ALL, 2'b00},
           {FRZ, 2'b10}, {RD3, 2'b00}, {ALL, 2'b00}};
    eb = '{{LU, 2'b00}, {RD2, 2'b01}, {ALL, 2'b00}, {ALL, 2'b00},
           {FRZ, 2'b10}, {RD2, 2'b00}, {ALL, 2'b00}};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: set_lu();
        1: begin set_bubble(); pcsel = 1; is_br = 1; end
        2: set_idle();
        3: begin set_idle(); pcsel = 1; end
        4: begin set_idle(); pcsel = 1; is_uncbr = 1; sram_stall = 1; end
        5: begin set_idle(); pcsel = 1; is_uncbr = 1; end
        default: set_idle();
      endcase
      #1;
      total++;
      if (obs_a !== ea[i]) begin bad++; $display("FAIL redir_a[%0d]: got=%b exp=%b", i, obs_a, ea[i]); end
      total++;
      if (obs_b !== eb[i]) begin bad++; $display("FAIL redir_b[%0d]: got=%b exp=%b", i, obs_b, eb[i]); end
      cyc();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    set_lu();
    cyc();
    set_bubble();
    #1;
    total++;
    if (obs_b !== {LU, 2'b01}) begin bad++; $display("FAIL rstmid_pre: got=%b exp=%b", obs_b, {LU, 2'b01}); end
    rst_n = 0;
    #1;
    total++;
    if (obs_b !== 10'b0) begin bad++; $display("FAIL rstmid_in: got=%b exp=%b", obs_b, 10'b0); end
    cyc();
    rst_n = 1;
    #1;
    total++;
    if (obs_b !== {ALL, 2'b00}) begin bad++; $display("FAIL rstmid_post: got=%b exp=%b", obs_b, {ALL, 2'b00}); end
    cyc();
    set_idle();
  endtask

`ifdef HDU_PERF_CNT_EN
  task automatic test_perf();
    set_idle();
    rst_n = 0;
    cyc();
    rst_n = 1;
    set_lu();      cyc();
    set_bubble();  cyc();
    set_idle();    cyc();
    set_lu();      cyc();
    set_bubble();  cyc();
    set_idle(); pcsel = 1; is_uncbr = 1; cyc();
    set_idle(); sram_stall = 1;
    for (int i = 0; i < 5; i++) cyc();
    set_idle();
    #1;
    total++;
    if (c_cnt_lu !== 32'd4) begin bad++; $display("FAIL perf_lu: got=%0d exp=%0d", c_cnt_lu, 4); end
    total++;
    if (c_cnt_flush !== 32'd1) begin bad++; $display("FAIL perf_flush: got=%0d exp=%0d", c_cnt_flush, 1); end
    total++;
    if (c_cnt_frz !== 32'd5) begin bad++; $display("FAIL perf_frz: got=%0d exp=%0d", c_cnt_frz, 5); end
    cyc();
    set_lu();
    cyc();
    set_bubble();
    #1;
    total++;
    if (obs_c !== {LU, 2'b01}) begin bad++; $display("FAIL perf_stall: got=%b exp=%b", obs_c, {LU, 2'b01}); end
    rst_n = 0;
    cyc();
    rst_n = 1;
    #1;
    total++;
    if (obs_c !== {ALL, 2'b00}) begin bad++; $display("FAIL perf_rst_run: got=%b exp=%b", obs_c, {ALL, 2'b00}); end
    total++;
    if (c_cnt_lu !== 32'd0) begin bad++; $display("FAIL perf_rst_cnt: got=%0d exp=%0d", c_cnt_lu, 0); end
    cyc();
    set_idle();
  endtask
`endif

  initial begin
    set_idle();
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_freeze();
    test_no_stall();
    test_redirect();
    test_reset_mid_stall();
`ifdef HDU_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
